// File: rtl/adc_spi_reader.sv
// SPI read-frame engine for an AD7476-style serial ADC, started by a one-cycle trigger.
// Optional `ADC_LEADING_ZERO_CHECK_EN adds o_adc_err, which flags nonzero leading frame bits.
//
// state | meaning
// IDLE  | waiting for trigger, cs_n high, sclk high
// SETUP | cs_n low, sclk high, D cycles before the first falling edge
// LOW   | sclk low for D cycles, data sampled on the rising edge that ends it
// HIGH  | sclk high for D cycles, the last bit raises cs_n
// QUIET | cs_n high for D cycles, then publish the result
module adc_spi_reader #(
    parameter int NB_DATA  = 12,
    parameter int NB_FRAME = 16,
    parameter int NB_DIV   = 8
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_adc_trigger,
    input  logic [NB_DIV-1:0]  i_clk_div,
    input  logic               i_adc_sdata,
    output logic               o_adc_cs_n,
    output logic               o_adc_sclk,
    output logic [NB_DATA-1:0] o_adc_val,
    output logic               o_adc_done,
    output logic               o_adc_valid,
    output logic               o_trig_overrun
`ifdef ADC_LEADING_ZERO_CHECK_EN
    ,
    output logic               o_adc_err
`endif
);

    localparam int NB_BCNT = $clog2(NB_FRAME) + 1;
`ifdef ADC_LEADING_ZERO_CHECK_EN
    localparam int SH_W = NB_FRAME;
`else
    // Leading bits are simply shifted out, so only the result bits are kept.
    localparam int SH_W = NB_DATA;
`endif

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, QUIET} state_t;

    state_t              state_q, state_d;
    logic [NB_DIV-1:0]   div_q, div_d;
    logic [NB_DIV-1:0]   cnt_q, cnt_d;
    logic [NB_BCNT-1:0]  bit_q, bit_d;
    logic [SH_W-1:0]     shift_q, shift_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic [NB_DATA-1:0]  val_q, val_d;
    logic                done_q, done_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;
    logic [NB_DIV-1:0]   div_eff;
    logic                tc;
`ifdef ADC_LEADING_ZERO_CHECK_EN
    logic                err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        val_d   = val_q;
        done_d  = done_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q;
`ifdef ADC_LEADING_ZERO_CHECK_EN
        err_d   = err_q;
`endif
        div_eff = (i_clk_div == '0) ? NB_DIV'(1) : i_clk_div;
        tc      = (cnt_q == '0);

        // Every busy state lasts div_q cycles; the counter reloads on terminal count.
        if (state_q != IDLE) begin
            if (i_adc_trigger) begin
                ovr_d = 1'b1;
            end
            if (tc) begin
                cnt_d = div_q - NB_DIV'(1);
            end else begin
                cnt_d = cnt_q - NB_DIV'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (i_adc_trigger) begin
                    div_d   = div_eff;
                    cnt_d   = div_eff - NB_DIV'(1);
                    done_d  = 1'b0;
                    cs_n_d  = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tc) begin
                    sclk_d  = 1'b0;
                    bit_d   = '0;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (tc) begin
                    sclk_d  = 1'b1;
                    shift_d = {shift_q[SH_W-2:0], i_adc_sdata};
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (tc) begin
                    if (bit_q == NB_BCNT'(NB_FRAME - 1)) begin
                        cs_n_d  = 1'b1;
                        state_d = QUIET;
                    end else begin
                        sclk_d  = 1'b0;
                        bit_d   = bit_q + NB_BCNT'(1);
                        state_d = LOW;
                    end
                end
            end
            QUIET: begin
                if (tc) begin
                    val_d   = shift_q[NB_DATA-1:0];
`ifdef ADC_LEADING_ZERO_CHECK_EN
                    err_d   = |shift_q[NB_FRAME-1:NB_DATA];
`endif
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                cs_n_d  = 1'b1;
                sclk_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            div_q   <= NB_DIV'(1);
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            val_q   <= '0;
            done_q  <= 1'b1;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef ADC_LEADING_ZERO_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            val_q   <= val_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef ADC_LEADING_ZERO_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign o_adc_cs_n     = cs_n_q;
    assign o_adc_sclk     = sclk_q;
    assign o_adc_val      = val_q;
    assign o_adc_done     = done_q;
    assign o_adc_valid    = valid_q;
    assign o_trig_overrun = ovr_q;
`ifdef ADC_LEADING_ZERO_CHECK_EN
    assign o_adc_err      = err_q;
`endif

endmodule

// File: tb/tb_adc_spi_reader.sv
// Scoreboard bench for adc_spi_reader: a serial ADC model plus a cycle-count reference
// of frame latency, overrun and result; a monitor compares every valid pulse.
module tb_adc_spi_reader;

    localparam int NB_DATA  = 12;
    localparam int NB_FRAME = 16;
    localparam int NB_DIV   = 8;
    localparam int BUDGET   = 20000;

    logic               clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_adc_trigger = 1'b0;
    logic [NB_DIV-1:0]  i_clk_div = 8'd4;
    logic               i_adc_sdata = 1'b0;
    logic               o_adc_cs_n;
    logic               o_adc_sclk;
    logic [NB_DATA-1:0] o_adc_val;
    logic               o_adc_done;
    logic               o_adc_valid;
    logic               o_trig_overrun;
`ifdef ADC_LEADING_ZERO_CHECK_EN
    logic               o_adc_err;
`endif

    adc_spi_reader #(.NB_DATA(NB_DATA), .NB_FRAME(NB_FRAME), .NB_DIV(NB_DIV)) dut (
        .clk            (clk),
        .i_rst          (i_rst),
        .i_adc_trigger  (i_adc_trigger),
        .i_clk_div      (i_clk_div),
        .i_adc_sdata    (i_adc_sdata),
        .o_adc_cs_n     (o_adc_cs_n),
        .o_adc_sclk     (o_adc_sclk),
        .o_adc_val      (o_adc_val),
        .o_adc_done     (o_adc_done),
        .o_adc_valid    (o_adc_valid),
        .o_trig_overrun (o_trig_overrun)
`ifdef ADC_LEADING_ZERO_CHECK_EN
        ,
        .o_adc_err      (o_adc_err)
`endif
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [NB_DATA-1:0] val;
        logic               err;
        longint             cyc;
    } exp_t;
    exp_t sb[$];

    logic [NB_FRAME-1:0] adc_frame = '0;
    int                  nf = 0;
    longint              busy_end = 0;
    logic                ovr_exp = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC: presents the next frame bit (MSB first) on each sclk fall while selected.
    always @(negedge o_adc_sclk or posedge o_adc_cs_n) begin
        if (o_adc_cs_n) begin
            nf = 0;
        end else if (nf < NB_FRAME) begin
            i_adc_sdata = adc_frame[NB_FRAME-1-nf];
            nf = nf + 1;
        end
    end

    always @(negedge clk) begin
        if (!i_rst && o_adc_valid) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("val", longint'(o_adc_val), longint'(e.val));
                chk("done_cycle", cyc, e.cyc);
                chk("done_with_valid", longint'(o_adc_done), 1);
`ifdef ADC_LEADING_ZERO_CHECK_EN
                chk("err", longint'(o_adc_err), longint'(e.err));
`endif
            end
        end
    end

    // Called at a negedge; the trigger is high for the current cycle only.
    task automatic trig(input logic [NB_DIV-1:0] d, input logic [NB_FRAME-1:0] frame);
        longint c = cyc;
        longint de = (d == 0) ? 1 : longint'(d);
        exp_t e;
        if (c > busy_end) begin
            adc_frame = frame;
            e.val = frame[NB_DATA-1:0];
            e.err = |frame[NB_FRAME-1:NB_DATA];
            e.cyc = c + 1 + 2 * de * (NB_FRAME + 1);
            sb.push_back(e);
            busy_end = c + 2 * de * (NB_FRAME + 1);
        end else begin
            ovr_exp = 1'b1;
        end
        i_clk_div = d;
        i_adc_trigger = 1'b1;
        @(negedge clk);
        i_adc_trigger = 1'b0;
    endtask

    task automatic wait_idle(output int falls);
        int n = 0;
        logic prev = o_adc_sclk;
        falls = 0;
        while ((sb.size() != 0 || !o_adc_done) && n < BUDGET) begin
            @(negedge clk);
            if (prev && !o_adc_sclk) falls++;
            prev = o_adc_sclk;
            n++;
        end
        if (n >= BUDGET) begin
            checks++;
            failures++;
            $display("FAIL wait_idle timeout pending=%0d expected=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!o_adc_valid && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) begin
            checks++;
            failures++;
            $display("FAIL wait_valid timeout actual=0 expected=1");
        end
    endtask

    initial begin
        int f;
        logic [NB_DIV-1:0]   d;
        logic [NB_FRAME-1:0] fr;

        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", longint'(o_adc_cs_n), 1);
        chk("rst_sclk", longint'(o_adc_sclk), 1);
        chk("rst_done", longint'(o_adc_done), 1);
        chk("rst_val", longint'(o_adc_val), 0);
        chk("rst_valid", longint'(o_adc_valid), 0);
        chk("rst_overrun", longint'(o_trig_overrun), 0);
        i_rst = 1'b0;
        busy_end = cyc;
        @(negedge clk);

        trig(8'd4, 16'h0ABC);
        chk("cs_n_low_after_trig", longint'(o_adc_cs_n), 0);
        chk("done_low_in_frame", longint'(o_adc_done), 0);
        wait_idle(f);
        chk("sclk_falls_d4", f, NB_FRAME);
        chk("val_held", longint'(o_adc_val), 12'hABC);

        fr = 16'($urandom) & 16'h0FFF;
        trig(8'd0, fr);
        wait_idle(f);
        chk("sclk_falls_d0", f, NB_FRAME);

        trig(8'd255, 16'h0FFF);
        wait_idle(f);
        chk("val_d255", longint'(o_adc_val), 12'hFFF);
        chk("no_overrun_yet", longint'(o_trig_overrun), 0);

        trig(8'd2, 16'h0123);
        repeat (9) @(negedge clk);
        trig(8'd7, 16'h0456);
        chk("overrun_set", longint'(o_trig_overrun), ovr_exp);
        wait_valid();
        trig(8'd3, 16'h0321);
        chk("b2b_cs_n_low", longint'(o_adc_cs_n), 0);
        wait_idle(f);
        chk("overrun_sticky", longint'(o_trig_overrun), ovr_exp);

        for (int i = 0; i < 12; i++) begin
            d  = 8'($urandom_range(0, 6));
            fr = 16'($urandom);
            if ($urandom_range(0, 1) == 1) fr[NB_FRAME-1:NB_DATA] = '0;
            trig(d, fr);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
                trig(8'($urandom), 16'($urandom));
            end else begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
                i_clk_div = 8'($urandom);
            end
            wait_idle(f);
            chk("rand_overrun", longint'(o_trig_overrun), ovr_exp);
        end

        trig(8'd1, 16'h0000);
        wait_idle(f);
        chk("val_zero_before_abort", longint'(o_adc_val), 0);
        trig(8'd4, 16'h0F0F);
        repeat (49) @(negedge clk);
        i_rst = 1'b1;
        sb.delete();
        busy_end = 0;
        ovr_exp = 1'b0;
        @(negedge clk);
        chk("abort_cs_n", longint'(o_adc_cs_n), 1);
        chk("abort_sclk", longint'(o_adc_sclk), 1);
        chk("abort_valid", longint'(o_adc_valid), 0);
        chk("abort_done", longint'(o_adc_done), 1);
        i_rst = 1'b0;
        busy_end = cyc;
        repeat (300) @(negedge clk);
        chk("abort_val", longint'(o_adc_val), 0);
        chk("abort_overrun", longint'(o_trig_overrun), ovr_exp);

`ifdef ADC_LEADING_ZERO_CHECK_EN
        trig(8'd3, 16'h8123);
        wait_idle(f);
        chk("err_set_val", longint'(o_adc_val), 12'h123);
        chk("err_set", longint'(o_adc_err), 1);
        trig(8'd3, 16'h0456);
        wait_idle(f);
        chk("err_clear", longint'(o_adc_err), 0);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
